hpdcache_mem_inval_ctrl: RTL and testbench
==========================================

# hpdcache_mem_inval_ctrl

Memory-side invalidation sequencer for the HPDcache. It accepts cache-line invalidation requests from the memory interconnect and buffers them in a small in-order FIFO. Each request is issued to the CMO handler as an invalidate-by-nline operation with the memory-invalidation qualifier held asserted until the handler finishes. On completion it returns an acknowledgement carrying the original request ID. It is the initiator for the CMO handler's memory-invalidation port and the responder toward the interconnect.

## Interface

Clock and reset: one clock; reset is asynchronous and active-high.

Parameters:
- `FIFO_DEPTH`, default 2: request FIFO entries, power of two, ≥2.
- `NLINE_WIDTH`, default 34: cache-line number width.
- `OFFSET_WIDTH`, default 6: byte-offset width within a line.
- `ID_WIDTH`, default 4: interconnect transaction ID width.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `mem_inval_req_valid_i`  in  1  interconnect invalidation request valid.
- `mem_inval_req_ready_o`  out  1  request accepted (FIFO not full).
- `mem_inval_req_nline_i`  in  `NLINE_WIDTH`  line number to invalidate.
- `mem_inval_req_id_i`  in  `ID_WIDTH`  request ID.
- `mem_inval_ack_valid_o`  out  1  acknowledgement valid.
- `mem_inval_ack_ready_i`  in  1  interconnect accepts the ack.
- `mem_inval_ack_id_o`  out  `ID_WIDTH`  ID of the completed request.
- `cmo_req_valid_o`  out  1  request to the CMO handler.
- `cmo_req_ready_i`  in  1  CMO handler idle/ready.
- `cmo_req_op_o`  out  `hpdcache_cmoh_op_t`  always `is_inval_by_nline`=1, all other fields 0.
- `cmo_req_addr_o`  out  `NLINE_WIDTH+OFFSET_WIDTH`  {head nline, `OFFSET_WIDTH`'b0}.
- `cmo_req_mem_inval_valid_o`  out  1  memory-invalidation qualifier.
- `cmo_mem_inval_ready_i`  in  1  CMO handler can take a memory invalidation.
- `busy_o`  out  1  FIFO non-empty or FSM not IDLE.

## Operation

- The FIFO pushes on `mem_inval_req_valid_i && mem_inval_req_ready_o`. `mem_inval_req_ready_o = !full`; there is no push-through-when-full, even when a pop occurs in the same cycle.
- The FIFO head is popped only on the ack handshake. Processing is strictly in order, one request in flight, with no merging of duplicate nlines; each duplicate is acked separately.

FSM states:
- IDLE
  - If FIFO non-empty: `cmo_req_valid_o=1` and `cmo_req_mem_inval_valid_o=1`, with addr/op from the head.
  - If `cmo_req_ready_i && cmo_mem_inval_ready_i`: go to WAIT. Otherwise hold, with outputs stable.
- WAIT
  - `cmo_req_valid_o=0`, `cmo_req_mem_inval_valid_o=1`, addr held.
  - The first cycle with `cmo_req_ready_i=1` goes to ACK (the handler has returned to idle).
- ACK
  - `mem_inval_ack_valid_o=1`, `mem_inval_ack_id_o` = head ID, `cmo_req_mem_inval_valid_o=0`.
  - On `mem_inval_ack_ready_i`: pop and go to IDLE.

Other rules:
- In ACK, `cmo_req_valid_o` and `cmo_req_mem_inval_valid_o` are 0; no new issue is allowed until the ack is taken.
- Ack ID and addr are combinational from the FIFO head and stay stable while the corresponding valid is high.
- FIFO pointers carry one extra wrap bit. full = pointers equal except the MSB; empty = pointers fully equal.

## Timing

Reset values:
- All valid/ready outputs 0, except `mem_inval_req_ready_o`=1.
- `busy_o`=0, FSM=IDLE, FIFO empty.
- `cmo_req_op_o` is constant; addr and ack ID read 0.

Latency and back-pressure:
- Latency with the handler idle and taking 3 cycles (issue, CHECK, SET): push at edge 0, issue handshake in cycle 1, WAIT cycles 2–4, `cmo_req_ready_i` seen in cycle 4, ack valid in cycle 5.
- If `mem_inval_ack_ready_i` is low, ack valid and ID hold indefinitely.
- A new request may be pushed in any cycle while not full, including during WAIT/ACK.

Reset during operation:
- Reset mid-operation, in any state, returns to IDLE and empties the FIFO.
- Outputs drop combinationally with reset assertion, since state is asynchronously cleared.
- No ack is produced for discarded requests.

## Test plan

- Single request, nline=0x1234, id=3, handler model idle → `cmo_req_addr_o`=0x48D00 in cycle 1, `cmo_req_mem_inval_valid_o` high cycles 1–4, ack id=3 in cycle 5.
- Back-to-back requests ids 1,2,3 with `FIFO_DEPTH`=2 → `mem_inval_req_ready_o` low once 2 are buffered; acks return in order 1,2,3; exactly one handler issue per request.
- `cmo_mem_inval_ready_i`=0 for 4 cycles after push → `cmo_req_valid_o` held with stable addr, no WAIT entry; issue occurs the cycle the input rises.
- `mem_inval_ack_ready_i` low for 5 cycles in ACK → ack valid/id stable, no new `cmo_req_valid_o`, FIFO count unchanged until the handshake.
- Duplicate nline 0x10 twice (ids 4,5) → two separate handler issues and acks 4 then 5.
- Assert `rst_i` during WAIT with 2 entries queued → next cycle all outputs at reset values, `busy_o`=0, no acks emitted.

Source files
------------

// File: rtl/hpdcache_mem_inval_ctrl.sv
// Memory-side invalidation sequencer: buffers interconnect line-invalidation
// requests in an in-order FIFO, issues each one to the CMO handler as an
// invalidate-by-nline with the memory-invalidation qualifier, and returns an
// acknowledgement carrying the original request ID once the handler is done.

package hpdcache_mem_inval_ctrl_pkg;
  // CMO handler operation encoding; exactly one flag is set per request
  typedef struct packed {
    logic is_fence;
    logic is_inval_by_nline;
    logic is_inval_by_set;
    logic is_inval_all;
    logic is_flush_by_nline;
    logic is_flush_by_set;
    logic is_flush_all;
    logic is_flush_inval_by_nline;
    logic is_flush_inval_by_set;
    logic is_flush_inval_all;
  } hpdcache_cmoh_op_t;
endpackage

module hpdcache_mem_inval_ctrl
  import hpdcache_mem_inval_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned NLINE_WIDTH  = 34,
  parameter int unsigned OFFSET_WIDTH = 6,
  parameter int unsigned ID_WIDTH     = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,

  // interconnect request channel
  input  logic                                mem_inval_req_valid_i,
  output logic                                mem_inval_req_ready_o,
  input  logic [NLINE_WIDTH-1:0]              mem_inval_req_nline_i,
  input  logic [ID_WIDTH-1:0]                 mem_inval_req_id_i,

  // interconnect acknowledgement channel
  output logic                                mem_inval_ack_valid_o,
  input  logic                                mem_inval_ack_ready_i,
  output logic [ID_WIDTH-1:0]                 mem_inval_ack_id_o,

  // CMO handler memory-invalidation port
  output logic                                cmo_req_valid_o,
  input  logic                                cmo_req_ready_i,
  output hpdcache_cmoh_op_t                   cmo_req_op_o,
  output logic [NLINE_WIDTH+OFFSET_WIDTH-1:0] cmo_req_addr_o,
  output logic                                cmo_req_mem_inval_valid_o,
  input  logic                                cmo_mem_inval_ready_i,

  output logic                                busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

  typedef struct packed {
    logic [NLINE_WIDTH-1:0] nline;
    logic [ID_WIDTH-1:0]    id;
  } inval_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e     state_q, state_d;

  inval_req_t fifo_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic       fifo_full, fifo_empty;
  logic       fifo_push, fifo_pop;
  inval_req_t head;

  // Pointers carry a wrap bit: equal pointers mean empty, equal except the
  // wrap bit means full.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // No push-through when full, even if the head is acked this cycle.
  assign mem_inval_req_ready_o = ~fifo_full;
  assign fifo_push = mem_inval_req_valid_i & ~fifo_full;

  assign head = fifo_q[rd_ptr_q[PTR_W-1:0]];

  // Address and ack ID come straight from the head so they stay stable for
  // as long as the entry is outstanding.
  assign cmo_req_addr_o     = {head.nline, {OFFSET_WIDTH{1'b0}}};
  assign mem_inval_ack_id_o = head.id;

  // Operation is fixed: invalidate by line number only
  always_comb begin
    cmo_req_op_o                   = '0;
    cmo_req_op_o.is_inval_by_nline = 1'b1;
  end

  assign busy_o = ~fifo_empty | (state_q != ST_IDLE);

  // FIFO pointer update; the head is retired only on the ack handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // FIFO storage; cleared on reset so addr and ack ID read zero afterwards
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (fifo_push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{nline: mem_inval_req_nline_i,
                                       id:    mem_inval_req_id_i};
    end
  end

  // Sequencer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Sequencer next state and handshake outputs. IDLE offers the head to the
  // handler; WAIT keeps the qualifier up until the handler reports ready
  // again (operation finished); ACK holds the ack until the interconnect
  // takes it, which is the only point where the head is popped.
  always_comb begin
    state_d                   = state_q;
    cmo_req_valid_o           = 1'b0;
    cmo_req_mem_inval_valid_o = 1'b0;
    mem_inval_ack_valid_o     = 1'b0;
    fifo_pop                  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          cmo_req_valid_o           = 1'b1;
          cmo_req_mem_inval_valid_o = 1'b1;
          if (cmo_req_ready_i && cmo_mem_inval_ready_i) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cmo_req_mem_inval_valid_o = 1'b1;
        if (cmo_req_ready_i) state_d = ST_ACK;
      end
      ST_ACK: begin
        mem_inval_ack_valid_o = 1'b1;
        if (mem_inval_ack_ready_i) begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hpdcache_mem_inval_ctrl.sv
// Self-checking bench for hpdcache_mem_inval_ctrl: directed scenarios plus a
// randomized phase, compared against a transaction-level reference model.
module tb_hpdcache_mem_inval_ctrl;
  import hpdcache_mem_inval_ctrl_pkg::*;

  localparam int DEPTH = 2;
  localparam int NW    = 34;
  localparam int OW    = 6;
  localparam int IW    = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 mem_inval_req_valid_i;
  logic                 mem_inval_req_ready_o;
  logic [NW-1:0]        mem_inval_req_nline_i;
  logic [IW-1:0]        mem_inval_req_id_i;
  logic                 mem_inval_ack_valid_o;
  logic                 mem_inval_ack_ready_i;
  logic [IW-1:0]        mem_inval_ack_id_o;
  logic                 cmo_req_valid_o;
  logic                 cmo_req_ready_i;
  hpdcache_cmoh_op_t    cmo_req_op_o;
  logic [NW+OW-1:0]     cmo_req_addr_o;
  logic                 cmo_req_mem_inval_valid_o;
  logic                 cmo_mem_inval_ready_i;
  logic                 busy_o;

  hpdcache_mem_inval_ctrl #(
    .FIFO_DEPTH(DEPTH), .NLINE_WIDTH(NW), .OFFSET_WIDTH(OW), .ID_WIDTH(IW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_inval_req_valid_i(mem_inval_req_valid_i),
    .mem_inval_req_ready_o(mem_inval_req_ready_o),
    .mem_inval_req_nline_i(mem_inval_req_nline_i),
    .mem_inval_req_id_i(mem_inval_req_id_i),
    .mem_inval_ack_valid_o(mem_inval_ack_valid_o),
    .mem_inval_ack_ready_i(mem_inval_ack_ready_i),
    .mem_inval_ack_id_o(mem_inval_ack_id_o),
    .cmo_req_valid_o(cmo_req_valid_o),
    .cmo_req_ready_i(cmo_req_ready_i),
    .cmo_req_op_o(cmo_req_op_o),
    .cmo_req_addr_o(cmo_req_addr_o),
    .cmo_req_mem_inval_valid_o(cmo_req_mem_inval_valid_o),
    .cmo_mem_inval_ready_i(cmo_mem_inval_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending requests in arrival order plus the progress of
  // the oldest one (0 = not yet issued, 1 = handler working, 2 = awaiting ack).
  typedef struct {
    logic [NW-1:0] nline;
    logic [IW-1:0] id;
  } req_t;

  req_t              mq[$];
  int                hstage;
  int                hcnt;          // handler model: cycles left with ready low
  bit                rnd_lat;
  bit                pushed;
  int                n_issue, n_exp_issue, nrdy_seen;
  logic [IW-1:0]     acks[$];
  hpdcache_cmoh_op_t exp_op;
  int                tests, failed;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Compare every output against what the model says must be visible now
  task automatic check_outputs();
    bit ne;
    ne = (mq.size() > 0);
    chk("req_ready", 64'(mem_inval_req_ready_o), 64'(mq.size() < DEPTH));
    chk("busy", 64'(busy_o), 64'(ne));
    chk("cmo_valid", 64'(cmo_req_valid_o), 64'(ne && hstage == 0));
    chk("mem_inval_valid", 64'(cmo_req_mem_inval_valid_o), 64'(ne && hstage < 2));
    chk("ack_valid", 64'(mem_inval_ack_valid_o), 64'(ne && hstage == 2));
    chk("op", 64'(cmo_req_op_o), 64'(exp_op));
    if (ne && hstage < 2) chk("addr", 64'(cmo_req_addr_o), 64'({mq[0].nline, {OW{1'b0}}}));
    if (ne && hstage == 2) chk("ack_id", 64'(mem_inval_ack_id_o), 64'(mq[0].id));
  endtask

  // One clock cycle: check, record handshakes, advance model and handler
  task automatic cyc();
    bit iss;
    #1;
    check_outputs();
    iss = cmo_req_valid_o && cmo_req_ready_i && cmo_mem_inval_ready_i;
    if (iss) n_issue++;
    if (mem_inval_ack_valid_o && mem_inval_ack_ready_i) acks.push_back(mem_inval_ack_id_o);
    if (mem_inval_req_valid_i && mq.size() >= DEPTH) nrdy_seen++;
    pushed = mem_inval_req_valid_i && (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      if (hstage == 0 && cmo_req_ready_i && cmo_mem_inval_ready_i) begin
        hstage = 1; n_exp_issue++;
      end else if (hstage == 1 && cmo_req_ready_i) begin
        hstage = 2;
      end else if (hstage == 2 && mem_inval_ack_ready_i) begin
        mq.delete(0); hstage = 0;
      end
    end
    if (pushed) mq.push_back('{mem_inval_req_nline_i, mem_inval_req_id_i});
    if (iss) hcnt = rnd_lat ? int'($urandom_range(1, 4)) : 2;
    else if (hcnt > 0) hcnt--;
    @(posedge clk_i); #1;
    cmo_req_ready_i = (hcnt == 0);
  endtask

  task automatic push_req(input logic [NW-1:0] nl, input logic [IW-1:0] id);
    int i;
    mem_inval_req_valid_i = 1'b1;
    mem_inval_req_nline_i = nl;
    mem_inval_req_id_i    = id;
    pushed = 1'b0;
    for (i = 0; i < 50 && !pushed; i++) cyc();
    chk("push_accepted", 64'(pushed), 64'd1);
    mem_inval_req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300 && mq.size() > 0; i++) cyc();
    chk("drain_empty", 64'(mq.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(mem_inval_req_ready_o), 64'd1);
    chk({tag, "_ack_valid"}, 64'(mem_inval_ack_valid_o), 64'd0);
    chk({tag, "_cmo_valid"}, 64'(cmo_req_valid_o), 64'd0);
    chk({tag, "_mi_valid"}, 64'(cmo_req_mem_inval_valid_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_addr"}, 64'(cmo_req_addr_o), 64'd0);
    chk({tag, "_ack_id"}, 64'(mem_inval_ack_id_o), 64'd0);
    chk({tag, "_op"}, 64'(cmo_req_op_o), 64'(exp_op));
  endtask

  initial begin
    int base_iss, base_ack, i;
    logic [NW+OW-1:0] held_addr;
    tests = 0; failed = 0;
    exp_op = '0; exp_op.is_inval_by_nline = 1'b1;
    hstage = 0; hcnt = 0; rnd_lat = 0;
    n_issue = 0; n_exp_issue = 0; nrdy_seen = 0;
    rst_i = 1'b1;
    mem_inval_req_valid_i = 0; mem_inval_req_nline_i = '0; mem_inval_req_id_i = '0;
    mem_inval_ack_ready_i = 1; cmo_req_ready_i = 1; cmo_mem_inval_ready_i = 1;
    #1;
    chk_reset_outputs("rst");
    @(posedge clk_i); @(posedge clk_i); #1;
    chk_reset_outputs("rst_held");
    rst_i = 1'b0;

    // Single request: addr 0x48D00 in cycle 1, qualifier cycles 1-4, ack cycle 5
    mem_inval_req_valid_i = 1; mem_inval_req_nline_i = 34'h1234; mem_inval_req_id_i = 3;
    cyc();
    mem_inval_req_valid_i = 0;
    #1;
    chk("t1_c1_addr", 64'(cmo_req_addr_o), 64'h48D00);
    chk("t1_c1_cvalid", 64'(cmo_req_valid_o), 64'd1);
    cyc();
    for (i = 2; i <= 4; i++) begin
      #1;
      chk("t1_wait_mi", 64'(cmo_req_mem_inval_valid_o), 64'd1);
      chk("t1_wait_cvalid", 64'(cmo_req_valid_o), 64'd0);
      chk("t1_wait_ackv", 64'(mem_inval_ack_valid_o), 64'd0);
      cyc();
    end
    #1;
    chk("t1_c5_ackv", 64'(mem_inval_ack_valid_o), 64'd1);
    chk("t1_c5_ackid", 64'(mem_inval_ack_id_o), 64'd3);
    chk("t1_c5_mi", 64'(cmo_req_mem_inval_valid_o), 64'd0);
    cyc();
    drain();

    // Back-to-back ids 1,2,3 with a two-entry FIFO
    base_iss = n_issue; base_ack = acks.size(); nrdy_seen = 0;
    push_req(34'h101, 1); push_req(34'h102, 2); push_req(34'h103, 3);
    drain();
    chk("t2_backpressure", 64'(nrdy_seen != 0), 64'd1);
    chk("t2_nacks", 64'(acks.size() - base_ack), 64'd3);
    chk("t2_ack0", 64'(acks[base_ack]), 64'd1);
    chk("t2_ack1", 64'(acks[base_ack + 1]), 64'd2);
    chk("t2_ack2", 64'(acks[base_ack + 2]), 64'd3);
    chk("t2_issues", 64'(n_issue - base_iss), 64'd3);

    // Handler refuses memory invalidations for 4 cycles after the push
    cmo_mem_inval_ready_i = 0;
    base_iss = n_issue;
    push_req(34'h2AA, 7);
    #1; held_addr = cmo_req_addr_o;
    chk("t3_addr", 64'(held_addr), 64'({34'h2AA, 6'b0}));
    for (i = 0; i < 4; i++) begin
      #1;
      chk("t3_cvalid_held", 64'(cmo_req_valid_o), 64'd1);
      chk("t3_addr_stable", 64'(cmo_req_addr_o), 64'(held_addr));
      cyc();
    end
    chk("t3_no_issue", 64'(n_issue - base_iss), 64'd0);
    cmo_mem_inval_ready_i = 1;
    cyc();
    chk("t3_issue_on_rise", 64'(n_issue - base_iss), 64'd1);
    drain();

    // Ack back-pressured for 5 cycles with a second entry queued
    mem_inval_ack_ready_i = 0;
    push_req(34'h3C, 9); push_req(34'h3D, 10);
    for (i = 0; i < 40 && !mem_inval_ack_valid_o; i++) begin
      cyc(); #1;
    end
    chk("t4_ack_reached", 64'(mem_inval_ack_valid_o), 64'd1);
    base_iss = n_issue;
    for (i = 0; i < 5; i++) begin
      #1;
      chk("t4_ackv_hold", 64'(mem_inval_ack_valid_o), 64'd1);
      chk("t4_ackid_hold", 64'(mem_inval_ack_id_o), 64'd9);
      chk("t4_no_cvalid", 64'(cmo_req_valid_o), 64'd0);
      chk("t4_full", 64'(mem_inval_req_ready_o), 64'd0);
      cyc();
    end
    chk("t4_no_issue", 64'(n_issue - base_iss), 64'd0);
    mem_inval_ack_ready_i = 1;
    drain();

    // Duplicate line numbers are issued and acked separately
    base_iss = n_issue; base_ack = acks.size();
    push_req(34'h10, 4); push_req(34'h10, 5);
    drain();
    chk("t5_issues", 64'(n_issue - base_iss), 64'd2);
    chk("t5_nacks", 64'(acks.size() - base_ack), 64'd2);
    chk("t5_ack0", 64'(acks[base_ack]), 64'd4);
    chk("t5_ack1", 64'(acks[base_ack + 1]), 64'd5);

    // Reset while waiting on the handler with two entries queued
    push_req(34'h55, 11); push_req(34'h56, 12);
    for (i = 0; i < 20 && !(cmo_req_mem_inval_valid_o && !cmo_req_valid_o); i++) begin
      cyc(); #1;
    end
    chk("t6_in_wait", 64'(cmo_req_mem_inval_valid_o && !cmo_req_valid_o), 64'd1);
    chk("t6_two_queued", 64'(mem_inval_req_ready_o), 64'd0);
    base_ack = acks.size();
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    mq.delete(); hstage = 0; hcnt = 0; cmo_req_ready_i = 1;
    @(posedge clk_i); #1;
    chk_reset_outputs("t6_next");
    rst_i = 1'b0;
    for (i = 0; i < 15; i++) cyc();
    chk("t6_no_acks", 64'(acks.size() - base_ack), 64'd0);
    chk("t6_idle", 64'(busy_o), 64'd0);

    // Randomized traffic against the model
    rnd_lat = 1;
    for (i = 0; i < 600; i++) begin
      mem_inval_req_valid_i = ($urandom_range(0, 1) == 1);
      mem_inval_req_nline_i = NW'({$urandom, $urandom});
      mem_inval_req_id_i    = IW'($urandom);
      mem_inval_ack_ready_i = ($urandom_range(0, 3) != 0);
      cmo_mem_inval_ready_i = ($urandom_range(0, 3) != 0);
      cyc();
    end
    mem_inval_req_valid_i = 0; mem_inval_ack_ready_i = 1; cmo_mem_inval_ready_i = 1;
    drain();
    chk("issue_total", 64'(n_issue), 64'(n_exp_issue));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
